ucie_sb_rx_deser: RTL and testbench
===================================

UCIE_SB_RX_DESER -- requirements
Module: ucie_sb_rx_deser

Interface
REQ-001 Parameter NC, default 32: width of one sideband chunk from the remote die; only 32 is supported.
REQ-002 Parameter FIFO_DEPTH, default 4: number of message entries buffered; must be a power of 2, at least 2.
REQ-003 Parameter GAP_TIMEOUT, default 16: idle cycles tolerated between chunks of one message before it is aborted.
REQ-004 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 i_rst  input  1  asynchronous, active-high reset.
REQ-006 i_sb_data_valid  input  1  remote chunk valid, one chunk per cycle when high.
REQ-007 i_data_received_sb  input  NC  remote sideband chunk.
REQ-008 i_msg_ready  input  1  local adapter accepts the head message.
REQ-009 o_msg_valid  output  1  FIFO is non-empty; head message presented.
REQ-010 o_msg_hdr  output  64  head message header.
REQ-011 o_msg_data  output  64  head message payload; 0 when o_msg_has_data=0.
REQ-012 o_msg_has_data  output  1  head message carries a payload.
REQ-013 o_parity_err  output  1  one-cycle pulse: message discarded on parity mismatch.
REQ-014 o_frame_err  output  1  one-cycle pulse: message aborted on gap timeout.
REQ-015 o_overflow  output  1  one-cycle pulse: good message dropped because the FIFO is full.
REQ-016 o_fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-017 Message format: header chunk 0 = hdr[31:0], then chunk 1 = hdr[63:32]; if hdr[4:0]==5'b11011, data chunk 0 = data[31:0], then chunk 1 = data[63:32]; no other opcode carries data.
REQ-018 FSM states: HDR_LO, HDR_HI, DATA_LO, DATA_HI; a valid chunk advances HDR_LO->HDR_HI, HDR_HI->DATA_LO when the opcode carries data, else HDR_HI->HDR_LO; DATA_LO->DATA_HI, DATA_HI->HDR_LO.
REQ-019 While i_sb_data_valid=0 the FSM holds its state.
REQ-020 Gap counter: cleared on every valid chunk and in HDR_LO; increments each idle cycle in any other state.
REQ-021 When the gap counter reaches GAP_TIMEOUT, the FSM returns to HDR_LO, the partial message is discarded, and o_frame_err pulses next cycle.
REQ-022 Parity (see REQ-036): hdr[63]=CP, even parity over hdr[62:0]; hdr[62]=DP, even parity over data[63:0], checked only when data is present.
REQ-023 Completion = last chunk accepted; a message with a parity failure is not written and o_parity_err pulses the next cycle.
REQ-024 A good message is written on the completion cycle, so o_msg_valid rises one cycle after the last chunk (latency 1).
REQ-025 Pop occurs when o_msg_valid && i_msg_ready; head outputs are stable while o_msg_valid=1 and i_msg_ready=0.
REQ-026 Push when full without simultaneous pop: message dropped, o_overflow pulses next cycle, count unchanged.
REQ-027 Push when full with simultaneous pop: push accepted, count unchanged.
REQ-028 Push and pop when not full/empty: count unchanged, FIFO order preserved.
REQ-029 Read/write pointers wrap modulo FIFO_DEPTH; count saturates at neither end beyond 0..FIFO_DEPTH.
REQ-030 o_msg_hdr/o_msg_data/o_msg_has_data are 0 when the FIFO is empty.

Reset
REQ-031 i_rst asserted forces, asynchronously: FSM=HDR_LO, gap counter=0, pointers=0, count=0.
REQ-032 While i_rst is asserted all outputs are 0.
REQ-033 Reset mid-message discards the partial message; no error pulse is generated for it.
REQ-034 FIFO contents are lost on reset; storage need not be cleared, but outputs obey REQ-030.
REQ-035 After i_rst deasserts, the first chunk accepted is treated as hdr[31:0].

Configuration
REQ-036 Macro UCIE_SB_RX_PARITY_CHK_EN defined: REQ-022/REQ-023 parity checking is active.
REQ-037 Macro UCIE_SB_RX_PARITY_CHK_EN undefined: CP/DP are ignored, every completed message is written subject to REQ-026, and o_parity_err is tied 0.

Verification
REQ-038 Header only: chunks 0x0000_0012 then 0x0000_0000 (CP correct) -> o_msg_valid=1 the cycle after, o_msg_hdr=0x0000_0000_0000_0012, o_msg_has_data=0, o_fifo_count=1.
REQ-039 Header 0x1B with data 0xDEAD_BEEF_0123_4567 (correct parity), valid gaps of 3 cycles between chunks -> o_msg_has_data=1 and o_msg_data matches exactly.
REQ-040 With the macro defined, header with CP flipped -> o_parity_err=1 for one cycle, o_fifo_count stays 0; with the macro undefined, the same stimulus is accepted.
REQ-041 Header lo only, then 16 idle cycles -> o_frame_err pulses once; the next chunk is decoded as a new header lo.
REQ-042 i_msg_ready=0, five good messages with FIFO_DEPTH=4 -> o_fifo_count=4, o_overflow pulses once on the fifth; then the sixth message completes while i_msg_ready=1 -> count stays 4.
REQ-043 i_rst pulsed between data chunk 0 and chunk 1 -> all outputs 0, and a following complete header-only message is received correctly.

Source files
------------

// File: rtl/ucie_sb_rx_deser_if.sv
// Sideband receive bundle: remote chunk stream in, buffered message head and status pulses out.
interface ucie_sb_rx_deser_if #(
  parameter int NC         = 32,
  parameter int FIFO_DEPTH = 4
);
  logic                          i_sb_data_valid;
  logic [NC-1:0]                 i_data_received_sb;
  logic                          i_msg_ready;
  logic                          o_msg_valid;
  logic [63:0]                   o_msg_hdr;
  logic [63:0]                   o_msg_data;
  logic                          o_msg_has_data;
  logic                          o_parity_err;
  logic                          o_frame_err;
  logic                          o_overflow;
  logic [$clog2(FIFO_DEPTH):0]   o_fifo_count;

  modport master (
    output i_sb_data_valid, i_data_received_sb, i_msg_ready,
    input  o_msg_valid, o_msg_hdr, o_msg_data, o_msg_has_data,
           o_parity_err, o_frame_err, o_overflow, o_fifo_count
  );

  modport slave (
    input  i_sb_data_valid, i_data_received_sb, i_msg_ready,
    output o_msg_valid, o_msg_hdr, o_msg_data, o_msg_has_data,
           o_parity_err, o_frame_err, o_overflow, o_fifo_count
  );
endinterface

// File: rtl/ucie_sb_rx_deser.sv
// Reassembles 32-bit sideband chunks into hdr/data messages and queues them; UCIE_SB_RX_PARITY_CHK_EN enables CP/DP checking.
// Message visible one cycle after its last chunk; i_msg_ready pops the head, a full FIFO drops new messages with o_overflow.
module ucie_sb_rx_deser #(
  parameter int NC          = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int GAP_TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  ucie_sb_rx_deser_if.slave sb
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = $clog2(GAP_TIMEOUT + 1);

  localparam logic [1:0] HDR_LO  = 2'd0;
  localparam logic [1:0] HDR_HI  = 2'd1;
  localparam logic [1:0] DATA_LO = 2'd2;
  localparam logic [1:0] DATA_HI = 2'd3;
  localparam logic [4:0] OP_DATA = 5'b11011;

  logic [1:0]    state;
  logic [GW-1:0] gap_cnt;
  logic [31:0]   hdr_lo_q, hdr_hi_q, data_lo_q;
  logic [NC-1:0] chunk_dat;
  logic          chunk;
  logic          gap_expire;
  logic          cmpl, cmpl_has;
  logic [63:0]   cmpl_hdr, cmpl_data;
  logic          par_bad;
  logic          push_req, push, pop, full, ovf;
  logic          frame_err_q, parity_err_q, overflow_q;

  logic [63:0]   hdr_mem  [FIFO_DEPTH];
  logic [63:0]   data_mem [FIFO_DEPTH];
  logic          has_mem  [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  assign chunk     = sb.i_sb_data_valid;
  assign chunk_dat = sb.i_data_received_sb;
  assign gap_expire = (state != HDR_LO) && !chunk && (gap_cnt == GW'(GAP_TIMEOUT - 1));

  always_comb begin
    cmpl      = 1'b0;
    cmpl_has  = 1'b0;
    cmpl_hdr  = {hdr_hi_q, hdr_lo_q};
    cmpl_data = '0;
    if (chunk && state == HDR_HI && hdr_lo_q[4:0] != OP_DATA) begin
      cmpl     = 1'b1;
      cmpl_hdr = {chunk_dat[31:0], hdr_lo_q};
    end else if (chunk && state == DATA_HI) begin
      cmpl      = 1'b1;
      cmpl_has  = 1'b1;
      cmpl_data = {chunk_dat[31:0], data_lo_q};
    end
  end

`ifdef UCIE_SB_RX_PARITY_CHK_EN
  // CP covers hdr[62:0] so the whole header XORs to 0; DP covers the payload
  assign par_bad = cmpl && ((^cmpl_hdr) || (cmpl_has && (cmpl_hdr[62] != ^cmpl_data)));
`else
  assign par_bad = 1'b0;
`endif

  assign full     = (count == CW'(FIFO_DEPTH));
  assign pop      = (count != '0) && sb.i_msg_ready;
  assign push_req = cmpl && !par_bad;
  assign push     = push_req && (!full || pop);
  assign ovf      = push_req && full && !pop;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= HDR_LO;
      gap_cnt     <= '0;
      hdr_lo_q    <= '0;
      hdr_hi_q    <= '0;
      data_lo_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= gap_expire;
      if (chunk) begin
        gap_cnt <= '0;
        case (state)
          HDR_LO:  begin hdr_lo_q  <= chunk_dat[31:0]; state <= HDR_HI;  end
          HDR_HI:  begin
            hdr_hi_q <= chunk_dat[31:0];
            state    <= (hdr_lo_q[4:0] == OP_DATA) ? DATA_LO : HDR_LO;
          end
          DATA_LO: begin data_lo_q <= chunk_dat[31:0]; state <= DATA_HI; end
          default: state <= HDR_LO;
        endcase
      end else if (state == HDR_LO) begin
        gap_cnt <= '0;
      end else if (gap_expire) begin
        state   <= HDR_LO;
        gap_cnt <= '0;
      end else begin
        gap_cnt <= gap_cnt + GW'(1);
      end
    end
  end

  // Storage is not reset; the outputs are masked by occupancy instead
  always_ff @(posedge i_clk) begin
    if (push) begin
      hdr_mem[wr_ptr]  <= cmpl_hdr;
      data_mem[wr_ptr] <= cmpl_data;
      has_mem[wr_ptr]  <= cmpl_has;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      parity_err_q <= par_bad;
      overflow_q   <= ovf;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  assign sb.o_msg_valid    = (count != '0);
  assign sb.o_msg_hdr      = sb.o_msg_valid ? hdr_mem[rd_ptr]  : '0;
  assign sb.o_msg_data     = sb.o_msg_valid ? data_mem[rd_ptr] : '0;
  assign sb.o_msg_has_data = sb.o_msg_valid ? has_mem[rd_ptr]  : 1'b0;
  assign sb.o_parity_err   = parity_err_q;
  assign sb.o_frame_err    = frame_err_q;
  assign sb.o_overflow     = overflow_q;
  assign sb.o_fifo_count   = count;
endmodule

// File: tb/tb_ucie_sb_rx_deser.sv
// Scoreboard bench: driver queues expected messages, negedge monitor checks head, count and error pulses.
module tb_ucie_sb_rx_deser;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [63:0] hdr;
    logic [63:0] data;
    logic        has;
  } msg_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ucie_sb_rx_deser_if #(.NC(32), .FIFO_DEPTH(DEPTH)) bus ();

  ucie_sb_rx_deser #(.NC(32), .FIFO_DEPTH(DEPTH), .GAP_TIMEOUT(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .sb    (bus)
  );

  int   errors = 0;
  int   checks = 0;
  int   frame_pulses = 0;
  int   ovf_pulses = 0;
  msg_t exp_q[$];
  msg_t m_cur;
  bit   m_ok;
  bit   drv_last = 0;
  bit   rand_rdy = 0;
  bit   exp_par = 0;
  bit   exp_ovf = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic bit model_ok(input logic [63:0] h, input logic [63:0] d, input bit has);
`ifdef UCIE_SB_RX_PARITY_CHK_EN
    bit cp_ok, dp_ok;
    cp_ok = (($countones(h[62:0]) + int'(h[63])) % 2) == 0;
    dp_ok = !has || ((($countones(d) + int'(h[62])) % 2) == 0);
    return cp_ok && dp_ok;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [63:0] with_parity(input logic [63:0] h, input logic [63:0] d);
    logic [63:0] r;
    r = h;
    if (r[4:0] == 5'h1B) r[62] = ($countones(d) % 2) == 1;
    r[63] = ($countones(r[62:0]) % 2) == 1;
    return r;
  endfunction

  // Monitor: compare DUT against the queue model, then apply this cycle's pop/push
  always @(negedge clk) begin
    int occ;
    bit pop_now;
    if (rst) begin
      exp_q.delete();
      exp_par = 0;
      exp_ovf = 0;
    end else begin
      chk("parity_err", {63'd0, bus.o_parity_err}, {63'd0, exp_par});
      chk("overflow",   {63'd0, bus.o_overflow},   {63'd0, exp_ovf});
      if (bus.o_frame_err) frame_pulses++;
      if (bus.o_overflow)  ovf_pulses++;
      exp_par = 0;
      exp_ovf = 0;
      occ = exp_q.size();
      chk("fifo_count", 64'(bus.o_fifo_count), 64'(occ));
      chk("msg_valid", {63'd0, bus.o_msg_valid}, {63'd0, occ != 0});
      if (occ != 0) begin
        chk("head_hdr",  bus.o_msg_hdr,  exp_q[0].hdr);
        chk("head_data", bus.o_msg_data, exp_q[0].data);
        chk("head_has",  {63'd0, bus.o_msg_has_data}, {63'd0, exp_q[0].has});
      end else begin
        chk("empty_hdr",  bus.o_msg_hdr,  64'd0);
        chk("empty_data", bus.o_msg_data, 64'd0);
      end
      pop_now = (occ != 0) && bus.i_msg_ready;
      if (pop_now) void'(exp_q.pop_front());
      if (drv_last && bus.i_sb_data_valid) begin
        if (!m_ok) exp_par = 1;
        else if (occ < DEPTH || pop_now) exp_q.push_back(m_cur);
        else exp_ovf = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.i_msg_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic drive_chunk(input logic [31:0] c, input bit last);
    bus.i_sb_data_valid    = 1'b1;
    bus.i_data_received_sb = c;
    drv_last = last;
    tick();
    bus.i_sb_data_valid    = 1'b0;
    bus.i_data_received_sb = $urandom;
    drv_last = 0;
  endtask

  task automatic send_msg(input logic [63:0] h, input logic [63:0] d, input int gap, input bit rdy_last);
    bit has;
    has = (h[4:0] == 5'h1B);
    m_cur.hdr  = h;
    m_cur.data = has ? d : 64'd0;
    m_cur.has  = has;
    m_ok = model_ok(h, d, has);
    drive_chunk(h[31:0], 0);
    idle(gap);
    if (has) begin
      drive_chunk(h[63:32], 0);
      idle(gap);
      drive_chunk(d[31:0], 0);
      idle(gap);
      if (rdy_last) bus.i_msg_ready = 1'b1;
      drive_chunk(d[63:32], 1);
    end else begin
      if (rdy_last) bus.i_msg_ready = 1'b1;
      drive_chunk(h[63:32], 1);
    end
  endtask

  task automatic rand_msg(input bit force_hdr_only, output logic [63:0] h, output logic [63:0] d);
    logic [4:0] op;
    op = 5'($urandom_range(0, 31));
    if (force_hdr_only && op == 5'h1B) op = 5'h12;
    if (!force_hdr_only && $urandom_range(0, 2) == 0) op = 5'h1B;
    d = {$urandom, $urandom};
    h = {$urandom, $urandom};
    h[4:0] = op;
    h = with_parity(h, d);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && bus.o_fifo_count != 0; i++) tick();
    @(negedge clk);
    chk("drain_count", 64'(bus.o_fifo_count), 64'd0);
    tick();
  endtask

  initial begin
    logic [63:0] h, d;
    int f0, o0;
    bus.i_sb_data_valid    = 1'b0;
    bus.i_data_received_sb = '0;
    bus.i_msg_ready        = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_valid", {63'd0, bus.o_msg_valid}, 64'd0);
    chk("rst_count", 64'(bus.o_fifo_count), 64'd0);
    chk("rst_hdr",   bus.o_msg_hdr, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // Header-only message, CP = 0 for 0x12
    send_msg(64'h0000_0000_0000_0012, 64'd0, 0, 0);
    @(negedge clk);
    chk("ho_valid", {63'd0, bus.o_msg_valid}, 64'd1);
    chk("ho_hdr",   bus.o_msg_hdr, 64'h12);
    chk("ho_has",   {63'd0, bus.o_msg_has_data}, 64'd0);
    chk("ho_count", 64'(bus.o_fifo_count), 64'd1);
    tick();
    bus.i_msg_ready = 1'b1;
    drain();

    // Data message with 3-cycle gaps between chunks
    bus.i_msg_ready = 1'b0;
    h = with_parity(64'h0000_0000_0000_001B, 64'hDEAD_BEEF_0123_4567);
    send_msg(h, 64'hDEAD_BEEF_0123_4567, 3, 0);
    @(negedge clk);
    chk("dm_has",  {63'd0, bus.o_msg_has_data}, 64'd1);
    chk("dm_data", bus.o_msg_data, 64'hDEAD_BEEF_0123_4567);
    tick();
    bus.i_msg_ready = 1'b1;
    drain();

    // CP flipped
    bus.i_msg_ready = 1'b0;
    send_msg(64'h8000_0000_0000_0012, 64'd0, 0, 0);
    @(negedge clk);
`ifdef UCIE_SB_RX_PARITY_CHK_EN
    chk("cp_bad_err",   {63'd0, bus.o_parity_err}, 64'd1);
    chk("cp_bad_count", 64'(bus.o_fifo_count), 64'd0);
`else
    chk("cp_bad_err",   {63'd0, bus.o_parity_err}, 64'd0);
    chk("cp_bad_count", 64'(bus.o_fifo_count), 64'd1);
`endif
    tick();
    bus.i_msg_ready = 1'b1;
    drain();

    // Lone header-lo followed by a long idle gap
    f0 = frame_pulses;
    drive_chunk(32'h0000_0012, 0);
    idle(20);
    chk("frame_pulses", 64'(frame_pulses - f0), 64'd1);
    send_msg(64'h0000_0000_0000_0012, 64'd0, 0, 0);
    @(negedge clk);
    chk("post_frame_valid", {63'd0, bus.o_msg_valid}, 64'd1);
    chk("post_frame_hdr",   bus.o_msg_hdr, 64'h12);
    tick();
    drain();

    // Fill past depth, then complete a message during a pop
    bus.i_msg_ready = 1'b0;
    o0 = ovf_pulses;
    for (int i = 0; i < 5; i++) begin
      rand_msg(1, h, d);
      send_msg(h, d, 0, 0);
    end
    tick();
    @(negedge clk);
    chk("full_count", 64'(bus.o_fifo_count), 64'd4);
    chk("ovf_pulses", 64'(ovf_pulses - o0), 64'd1);
    tick();
    rand_msg(1, h, d);
    send_msg(h, d, 1, 1);
    @(negedge clk);
    chk("push_pop_full_count", 64'(bus.o_fifo_count), 64'd4);
    tick();
    drain();

    // Reset between data chunk 0 and 1 with a queued message
    bus.i_msg_ready = 1'b0;
    rand_msg(1, h, d);
    send_msg(h, d, 0, 0);
    h = with_parity(64'h0000_0000_0000_001B, 64'h1111_2222_3333_4444);
    f0 = frame_pulses;
    drive_chunk(h[31:0], 0);
    drive_chunk(h[63:32], 0);
    drive_chunk(32'h3333_4444, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", {63'd0, bus.o_msg_valid}, 64'd0);
    chk("mid_rst_count", 64'(bus.o_fifo_count), 64'd0);
    chk("mid_rst_hdr",   bus.o_msg_hdr, 64'd0);
    chk("mid_rst_data",  bus.o_msg_data, 64'd0);
    chk("mid_rst_errs",  {61'd0, bus.o_parity_err, bus.o_frame_err, bus.o_overflow}, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    send_msg(64'h0000_0000_0000_0012, 64'd0, 0, 0);
    @(negedge clk);
    chk("post_rst_valid", {63'd0, bus.o_msg_valid}, 64'd1);
    chk("post_rst_hdr",   bus.o_msg_hdr, 64'h12);
    chk("post_rst_count", 64'(bus.o_fifo_count), 64'd1);
    idle(3);
    chk("post_rst_frame", 64'(frame_pulses - f0), 64'd0);
    bus.i_msg_ready = 1'b1;
    drain();

    // Random traffic with random backpressure and occasional bad parity
    rand_rdy = 1;
    for (int i = 0; i < 150; i++) begin
      rand_msg(0, h, d);
      if ($urandom_range(0, 4) == 0) h[63] = ~h[63];
      send_msg(h, d, $urandom_range(0, 4), 0);
    end
    rand_rdy = 0;
    bus.i_msg_ready = 1'b1;
    drain();
    chk("total_frame_pulses", 64'(frame_pulses), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
